// File: rtl/pool_pkg.sv
// Shared definitions for the pooling tile sequencer: FSM states and the
// helper that maps a raster pixel index onto its 2x2 quadrant number.
package pool_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        MERGE   = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Quadrant numbering: 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
    function automatic logic [1:0] quadrant_of(input int idx, input int width_in,
                                               input int width_out);
        logic [1:0] qd;
        qd[0] = ((idx % width_in) >= width_out);
        qd[1] = ((idx / width_in) >= width_out);
        return qd;
    endfunction

endpackage

// File: rtl/pool_sequencer.sv
// Feeds four input tiles through an external pooling datapath, one quadrant
// per tile, and assembles the pooled quadrants into one output tile.
module pool_sequencer
    import pool_pkg::*;
#(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH_IN*WIDTH_IN-1:0][31:0]   in_pixels,
    output logic [WIDTH_IN*WIDTH_IN-1:0][31:0]   pool_pixels_in,
    output logic [1:0]                           pool_sub_block,
    input  logic [WIDTH_IN*WIDTH_IN-1:0][31:0]   pool_pixels_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH_IN*WIDTH_IN-1:0][31:0]   out_pixels,
    input  logic                                 abort,
    output logic [15:0]                          tiles_done
);

    localparam int NPIX = WIDTH_IN * WIDTH_IN;

    state_t                 state, state_nxt;
    logic [1:0]             q;
    logic [NPIX-1:0][31:0]  acc;
    logic [15:0]            done_cnt;
    logic                   accept;
    logic                   emit_fire;

    // abort masks both handshakes so nothing is taken or delivered in its cycle
    always_comb begin
        in_ready  = (state == COLLECT) && !abort;
        out_valid = (state == EMIT);
        accept    = in_valid && in_ready;
        emit_fire = out_valid && out_ready && !abort;
        state_nxt = state;
        unique case (state)
            COLLECT: if (accept)    state_nxt = MERGE;
            MERGE:   state_nxt = (q == 2'd3) ? EMIT : COLLECT;
            EMIT:    if (emit_fire) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
        if (abort) state_nxt = COLLECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            q        <= 2'd0;
            done_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            if (abort)
                q <= 2'd0;
            else if (state == MERGE)
                q <= q + 2'd1;
            if (emit_fire)
                done_cnt <= done_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pool_pixels_in <= '0;
        else if (accept)
            pool_pixels_in <= in_pixels;
    end

    // Only quadrant q is taken from the datapath; the rest of its output is don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (abort || emit_fire) begin
            acc <= '0;
        end else if (state == MERGE) begin
            for (int i = 0; i < NPIX; i++) begin
                if (quadrant_of(i, WIDTH_IN, WIDTH_OUT) == q)
                    acc[i] <= pool_pixels_out[i];
            end
        end
    end

    assign pool_sub_block = q;
    assign out_pixels     = acc;
    assign tiles_done     = done_cnt;

endmodule

// File: tb/tb_pool_sequencer.sv
// Scoreboard bench for pool_sequencer with a 2x2 max-pool datapath model.
module tb_pool_sequencer;

    localparam int WI = 8;
    localparam int WO = 4;
    localparam int NP = WI * WI;

    typedef logic [NP-1:0][31:0] tile_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    tile_t       in_pixels = '0;
    tile_t       pool_pixels_in;
    logic [1:0]  pool_sub_block;
    tile_t       pool_pixels_out;
    logic        out_valid;
    logic        out_ready;
    tile_t       out_pixels;
    logic        abort = 1'b0;
    logic [15:0] tiles_done;

    logic        rdy_fixed = 1'b1;
    logic        rand_bp = 1'b0;
    logic        rand_rdy = 1'b0;

    int          vectors = 0;
    int          miscompares = 0;
    int          hs_count = 0;
    logic [15:0] done_base = 16'd0;
    tile_t       part[$];
    tile_t       exp_q[$];

    always #5 clk = ~clk;

    assign out_ready = rand_bp ? rand_rdy : rdy_fixed;
    always @(posedge clk) rand_rdy <= 1'($urandom_range(0, 1));

    pool_sequencer #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixels(in_pixels), .pool_pixels_in(pool_pixels_in),
        .pool_sub_block(pool_sub_block), .pool_pixels_out(pool_pixels_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixels(out_pixels),
        .abort(abort), .tiles_done(tiles_done)
    );

    function automatic logic [31:0] max2(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    // 2x2 max over the input tile feeding pooled pixel (r,c) of a quadrant.
    function automatic logic [31:0] pool2x2(input tile_t t, input int r, input int c);
        return max2(max2(t[(2*r)*WI + 2*c], t[(2*r)*WI + 2*c + 1]),
                    max2(t[(2*r+1)*WI + 2*c], t[(2*r+1)*WI + 2*c + 1]));
    endfunction

    // Pooling datapath model: valid only inside the selected quadrant, garbage elsewhere.
    always_comb begin
        pool_pixels_out = '0;
        for (int i = 0; i < NP; i++) begin
            if ((((i / WI) / WO) * 2 + (i % WI) / WO) == int'(pool_sub_block))
                pool_pixels_out[i] = pool2x2(pool_pixels_in, (i / WI) % WO, (i % WI) % WO);
            else
                pool_pixels_out[i] = 32'hDEADBEEF;
        end
    end

    function automatic tile_t assemble();
        tile_t res;
        res = '0;
        for (int qd = 0; qd < 4; qd++)
            for (int r = 0; r < WO; r++)
                for (int c = 0; c < WO; c++)
                    res[(c + WO*(qd % 2)) + (r + WO*(qd / 2))*WI] = pool2x2(part[qd], r, c);
        return res;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int i = 0; i < NP; i++) t[i] = $urandom;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic check_tile(input string name, input tile_t act, input tile_t exp);
        int bad;
        bad = -1;
        vectors++;
        for (int i = 0; i < NP; i++)
            if (bad < 0 && act[i] !== exp[i]) bad = i;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: pixel %0d got 0x%08h, expected 0x%08h",
                     name, bad, act[bad], exp[bad]);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out", name);
    endtask

    // Scoreboard monitor: a delivered tile must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (abort) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_out_tile");
                end else begin
                    check_tile("out_pixels", out_pixels, exp_q.pop_front());
                    check("tiles_done_at_emit", {16'd0, tiles_done},
                          {16'd0, 16'(done_base + 16'(hs_count))});
                    hs_count++;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        abort = 1'b0;
        part.delete();
        exp_q.delete();
        done_base = 16'(0 - hs_count);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_tile(input tile_t t);
        bit ok;
        ok = 1'b0;
        in_pixels = t;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (!ok) begin
            timeout_fail("in_ready_wait");
            return;
        end
        part.push_back(t);
        if (part.size() == 4) begin
            exp_q.push_back(assemble());
            part.delete();
        end
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("out_valid_wait");
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 1000 && exp_q.size() > 0; k++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) timeout_fail("scoreboard_drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tile_t t, ptile, snap, pin, keep;

        // Reset state
        do_reset();
        @(negedge clk);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check("rst_tiles_done", {16'd0, tiles_done}, 32'd0);
        check("rst_sub_block", {30'd0, pool_sub_block}, 32'd0);
        check_tile("rst_out_pixels", out_pixels, '0);
        check_tile("rst_pool_pixels_in", pool_pixels_in, '0);
        @(posedge clk); #1;

        // Constant tiles 4,8,12,16 with latency and partial-accumulator checks
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NP; i++) t[i] = 32'(4 * (n + 1));
            send_tile(t);
            @(negedge clk);
            check_bit("merge_in_ready", in_ready, 1'b0);
            check_bit("merge_out_valid", out_valid, 1'b0);
            @(negedge clk);
            if (n < 3) begin
                check_bit("next_in_ready", in_ready, 1'b1);
                check("sub_block", {30'd0, pool_sub_block}, 32'(n + 1));
                ptile = '0;
                for (int qd = 0; qd <= n; qd++)
                    for (int r = 0; r < WO; r++)
                        for (int c = 0; c < WO; c++)
                            ptile[(c + WO*(qd % 2)) + (r + WO*(qd / 2))*WI] = 32'(4 * (qd + 1));
                check_tile("partial_acc", out_pixels, ptile);
            end else begin
                check_bit("emit_out_valid", out_valid, 1'b1);
                check_bit("emit_in_ready", in_ready, 1'b0);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("tiles_done_first", {16'd0, tiles_done}, 32'd1);
        check_bit("post_emit_in_ready", in_ready, 1'b1);
        check_tile("post_emit_cleared", out_pixels, '0);
        @(posedge clk); #1;

        // Backpressure in EMIT
        do_reset();
        rdy_fixed = 1'b0;
        for (int n = 0; n < 4; n++) send_tile(rand_tile());
        wait_out_valid();
        snap = out_pixels;
        pin = pool_pixels_in;
        @(posedge clk); #1;
        in_pixels = rand_tile();
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_tile("bp_out_stable", out_pixels, snap);
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_tile("bp_input_ignored", pool_pixels_in, pin);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain();
        @(negedge clk);
        check("bp_tiles_done", {16'd0, tiles_done}, 32'd1);
        @(posedge clk); #1;

        // Abort after two tiles, with a simultaneous input offer
        do_reset();
        send_tile(rand_tile());
        keep = rand_tile();
        send_tile(keep);
        @(posedge clk); #1;
        abort = 1'b1;
        in_pixels = rand_tile();
        in_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        part.delete();
        @(negedge clk);
        check_bit("abort_no_accept", in_ready, 1'b1);
        check("abort_q", {30'd0, pool_sub_block}, 32'd0);
        check_tile("abort_acc_clear", out_pixels, '0);
        check_tile("abort_pool_in_held", pool_pixels_in, keep);
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) send_tile(rand_tile());
        wait_drain();
        @(negedge clk);
        check("abort_then_tile", {16'd0, tiles_done}, 32'd1);
        @(posedge clk); #1;

        // Abort while holding a finished tile
        rdy_fixed = 1'b0;
        for (int n = 0; n < 4; n++) send_tile(rand_tile());
        wait_out_valid();
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        rdy_fixed = 1'b1;
        @(negedge clk);
        check_bit("emit_abort_valid", out_valid, 1'b0);
        check("emit_abort_count", {16'd0, tiles_done}, 32'd1);
        check_tile("emit_abort_clear", out_pixels, '0);
        @(posedge clk); #1;

        // Reset during MERGE of quadrant 2
        send_tile(rand_tile());
        send_tile(rand_tile());
        send_tile(rand_tile());
        check("pre_reset_q", {30'd0, pool_sub_block}, 32'd2);
        rst_n = 1'b0;
        part.delete();
        exp_q.delete();
        done_base = 16'(0 - hs_count);
        #1;
        check_bit("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_tiles_done", {16'd0, tiles_done}, 32'd0);
        check("mid_rst_q", {30'd0, pool_sub_block}, 32'd0);
        check_tile("mid_rst_out_pixels", out_pixels, '0);
        check_tile("mid_rst_pool_in", pool_pixels_in, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) send_tile(rand_tile());
        wait_drain();

        // Random traffic with random output backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 48; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_tile(rand_tile());
        end
        wait_drain();
        rand_bp = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Counter wrap: preload near 0xFFFF instead of delivering 65533 tiles
        force dut.done_cnt = 16'hFFFD;
        #1 release dut.done_cnt;
        done_base = 16'(16'hFFFD - 16'(hs_count));
        @(negedge clk);
        check("preset_tiles_done", {16'd0, tiles_done}, 32'h0000FFFD);
        @(posedge clk); #1;
        for (int n = 0; n < 12; n++) send_tile(rand_tile());
        wait_drain();
        @(negedge clk);
        check("wrap_tiles_done", {16'd0, tiles_done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
